// File: rtl/s27_pkg.sv
// Shared types and constants for the scan-inserted multi-channel s27 array.
package s27_pkg;

  // Per-channel s27 state; g5 sits at bit 0 so a 3-bit chain slice maps directly.
  typedef struct packed {
    logic g7;
    logic g6;
    logic g5;
  } s27_state_t;

  localparam logic [15:0] S27_DEFAULT_POLY = 16'h1021;

  function automatic int chain_len(input int channels);
    return 3 * channels;
  endfunction

endpackage

// File: rtl/s27_core.sv
// Combinational next-state and G17 logic of one s27 channel.
module s27_core
  import s27_pkg::*;
(
  input  logic       i_g0,
  input  logic       i_g1,
  input  logic       i_g2,
  input  logic       i_g3,
  input  s27_state_t i_state,
  output s27_state_t o_next,
  output logic       o_g17
);

  logic w_g8, w_g9, w_g10, w_g11, w_g12, w_g13, w_g14, w_g15, w_g16;

  assign w_g14 = ~i_g0;
  assign w_g12 = ~(i_g1 | i_state.g7);
  assign w_g8  = w_g14 & i_state.g6;
  assign w_g15 = w_g12 | w_g8;
  assign w_g16 = i_g3 | w_g8;
  assign w_g9  = ~(w_g16 & w_g15);
  assign w_g11 = ~(i_state.g5 | w_g9);
  assign w_g10 = ~(w_g14 | w_g11);
  assign w_g13 = ~(i_g2 | w_g12);

  assign o_g17     = ~w_g11;
  assign o_next.g5 = w_g10;
  assign o_next.g6 = w_g11;
  assign o_next.g7 = w_g13;

endmodule

// File: rtl/s27_scan_array.sv
// CHANNELS independent s27 cores sharing one mux-D scan chain, with a MISR over G17.
module s27_scan_array
  import s27_pkg::*;
#(
  parameter int                CHANNELS = 4,
  parameter int                SIG_W    = 16,
  parameter logic [SIG_W-1:0]  POLY     = SIG_W'(S27_DEFAULT_POLY)
) (
  input  logic                CK,
  input  logic                RN,
  input  logic [CHANNELS-1:0] G0,
  input  logic [CHANNELS-1:0] G1,
  input  logic [CHANNELS-1:0] G2,
  input  logic [CHANNELS-1:0] G3,
  input  logic                SE,
  input  logic                SI,
  output logic                SO,
  input  logic                SIG_EN,
  input  logic                SIG_CLR,
  output logic [CHANNELS-1:0] G17,
  output logic [SIG_W-1:0]    SIG
);

  localparam int L = chain_len(CHANNELS);

  logic [L-1:0]     r_chain;
  logic [L-1:0]     w_func_next;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_g17_ext;
  logic [SIG_W-1:0] w_misr_next;

  // Channel c owns chain bits 3c..3c+2 as {g7,g6,g5}.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    s27_state_t w_cur;
    s27_state_t w_nxt;
    logic       w_g17;

    assign w_cur = r_chain[3*c +: 3];

    s27_core u_core (
      .i_g0    (G0[c]),
      .i_g1    (G1[c]),
      .i_g2    (G2[c]),
      .i_g3    (G3[c]),
      .i_state (w_cur),
      .o_next  (w_nxt),
      .o_g17   (w_g17)
    );

    assign w_func_next[3*c +: 3] = w_nxt;
    assign G17[c]                = w_g17;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_chain <= '0;
    end else if (SE) begin
      r_chain <= {r_chain[L-2:0], SI};
    end else begin
      r_chain <= w_func_next;
    end
  end

  always_comb begin
    w_g17_ext                 = '0;
    w_g17_ext[CHANNELS-1:0]   = G17;
    w_misr_next = {r_sig[SIG_W-2:0], 1'b0}
                ^ (r_sig[SIG_W-1] ? POLY : '0)
                ^ w_g17_ext;
  end

  // Compaction is suppressed while shifting so scan traffic never perturbs the signature.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_sig <= '0;
    end else if (SIG_CLR) begin
      r_sig <= '0;
    end else if (SIG_EN && !SE) begin
      r_sig <= w_misr_next;
    end
  end

  assign SO  = r_chain[L-1];
  assign SIG = r_sig;

endmodule

// File: tb/tb_s27_scan_array.sv
// Directed and randomized checks of s27_scan_array against a behavioural model.
module tb_s27_scan_array;

  localparam int          CH = 4;
  localparam int          SW = 16;
  localparam logic [15:0] PL = 16'h1021;
  localparam int          L  = 3 * CH;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic [CH-1:0] G0 = '0, G1 = '0, G2 = '0, G3 = '0;
  logic          SE = 1'b0, SI = 1'b0, SIG_EN = 1'b0, SIG_CLR = 1'b0;
  logic          SO;
  logic [CH-1:0] G17;
  logic [SW-1:0] SIG;

  int total = 0;
  int bad   = 0;

  logic [L-1:0]  mChain = '0;
  logic [SW-1:0] mSig   = '0;

  s27_scan_array #(.CHANNELS(CH), .SIG_W(SW), .POLY(PL)) dut (
    .CK(CK), .RN(RN), .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .SE(SE), .SI(SI), .SO(SO), .SIG_EN(SIG_EN), .SIG_CLR(SIG_CLR),
    .G17(G17), .SIG(SIG)
  );

  always #5 CK = ~CK;

  // Returns {G17, G7next, G6next, G5next} for one channel; st is {G7,G6,G5}.
  function automatic logic [3:0] evalChan(input logic a0, a1, a2, a3, input logic [2:0] st);
    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
    g14 = ~a0;
    g12 = ~(a1 | st[2]);
    g8  = g14 & st[1];
    g15 = g12 | g8;
    g16 = a3 | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st[0] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(a2 | g12);
    return {~g11, g13, g11, g10};
  endfunction

  function automatic logic [CH-1:0] expG17();
    logic [CH-1:0] g;
    logic [3:0]    r;
    for (int c = 0; c < CH; c++) begin
      r    = evalChan(G0[c], G1[c], G2[c], G3[c], mChain[3*c +: 3]);
      g[c] = r[3];
    end
    return g;
  endfunction

  function automatic logic [L-1:0] expChainNext();
    logic [L-1:0] n;
    logic [3:0]   r;
    if (SE) return {mChain[L-2:0], SI};
    for (int c = 0; c < CH; c++) begin
      r = evalChan(G0[c], G1[c], G2[c], G3[c], mChain[3*c +: 3]);
      n[3*c +: 3] = r[2:0];
    end
    return n;
  endfunction

  function automatic logic [SW-1:0] expSigNext();
    logic [SW-1:0] s;
    if (SIG_CLR) return '0;
    if (!(SIG_EN && !SE)) return mSig;
    s = (mSig << 1) ^ (mSig[SW-1] ? PL : 16'h0000);
    s = s ^ {{(SW-CH){1'b0}}, expG17()};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "/so"},    32'(SO),          32'(mChain[L-1]));
    chk({tag, "/g17"},   32'(G17),         32'(expG17()));
    chk({tag, "/sig"},   32'(SIG),         32'(mSig));
    chk({tag, "/chain"}, 32'(dut.r_chain), 32'(mChain));
  endtask

  task automatic applyStimulus(input logic [CH-1:0] a0, a1, a2, a3,
                               input logic se, si, en, clr);
    G0 = a0; G1 = a1; G2 = a2; G3 = a3;
    SE = se; SI = si; SIG_EN = en; SIG_CLR = clr;
    #1;
  endtask

  task automatic tick();
    logic [L-1:0]  nC;
    logic [SW-1:0] nS;
    nC = expChainNext();
    nS = expSigNext();
    @(posedge CK);
    #1;
    mChain = nC;
    mSig   = nS;
  endtask

  task automatic doReset();
    @(negedge CK);
    RN = 1'b0;
    #1;
    mChain = '0;
    mSig   = '0;
    @(negedge CK);
    RN = 1'b1;
  endtask

  initial begin
    #3;
    chk("reset/chain", 32'(dut.r_chain), 32'h0);
    chk("reset/so",    32'(SO),          32'h0);
    chk("reset/sig",   32'(SIG),         32'h0);
    chk("reset/g17",   32'(G17),         32'hF);
    doReset();

    // Channel 0 G0 high for one functional edge
    applyStimulus(4'b0001, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("g0/chain", 32'(dut.r_chain), 32'h001);
    chk("g0/g17",   32'(G17),         32'hF);
    checkOutput("g0");

    // G3 on channel 0 pulls G17[0] low before the edge
    doReset();
    applyStimulus('0, '0, '0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("g3/g17pre", 32'(G17), 32'hE);
    tick();
    chk("g3/chain", 32'(dut.r_chain), 32'h002);
    checkOutput("g3");

    // Single one shifted through the whole chain
    doReset();
    applyStimulus('0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("scan/so_pre", 32'(SO), 32'h0);
    tick();
    SI = 1'b0;
    for (int e = 2; e <= L + 1; e++) begin
      chk("scan/so", 32'(SO), 32'(e - 1 == L));
      tick();
    end
    chk("scan/so_end", 32'(SO), 32'h0);
    checkOutput("scan");

    // Signature of an idle array
    doReset();
    applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("misr/e1", 32'(SIG), 32'h000F);
    tick();
    chk("misr/e2", 32'(SIG), 32'h0011);
    applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("misr/clr", 32'(SIG), 32'h0000);
    applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus('0, '0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("misr/scanhold", 32'(SIG), 32'h000F);
    checkOutput("misr");

    // Randomized mix of capture, shift, compaction and clear
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(CH'($urandom), CH'($urandom), CH'($urandom), CH'($urandom),
                    1'($urandom_range(0, 3) == 0), 1'($urandom),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      chk("rand/g17pre", 32'(G17), 32'(expG17()));
      tick();
      checkOutput("rand");
    end

    // Asynchronous reset in the middle of a shift
    applyStimulus('1, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus('1, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("arst/sig_nz", 32'(SIG != '0), 32'h1);
    #2;
    RN = 1'b0;
    #1;
    mChain = '0;
    mSig   = '0;
    checkOutput("arst");
    chk("arst/so0", 32'(SO), 32'h0);
    @(negedge CK);
    RN = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
